isr_seq_ctrl: RTL and testbench

- Interrupt entry/exit sequencer for the 5-stage MIPS pipeline, beside the PC control unit.
- Latches an external interrupt request and waits until the pipeline can accept it: no stall, no jump/branch in flight, and in-flight EX/MEM work drained.
- Then redirects fetch to the ISR vector, saves the return PC (EPC) and flushes IF/ID and ID/EX.
- On RETI it redirects fetch back to EPC.

---
 rtl/isr_seq_ctrl_pkg.sv | 23 ++
 rtl/isr_drain_cnt.sv | 34 +++
 rtl/isr_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_isr_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/isr_seq_ctrl_pkg.sv
// Shared definitions for the interrupt entry/exit sequencer.
// Provides the state encoding, the PC-select constants that the fetch PC mux
// also decodes, and the width helper for the drain counter.
package isr_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_ENTER   = 3'd2,
        ST_SERVICE = 3'd3,
        ST_RETURN  = 3'd4
    } isr_state_e;

    localparam logic [1:0] PC_SRC_SEQ = 2'b00;
    localparam logic [1:0] PC_SRC_VEC = 2'b01;
    localparam logic [1:0] PC_SRC_EPC = 2'b10;

    // Bits needed to hold 0..n inclusive (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/isr_drain_cnt.sv
// Drain counter: counts consecutive clean pipeline cycles before interrupt entry.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   i_clr       - clear to zero (wins over increment)
//   i_inc       - increment; otherwise the count holds
//   o_last_c    - combinational flag, count is at DRAIN_CYCLES-1
module isr_drain_cnt
    import isr_seq_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_last_c
);

    localparam int unsigned CW = cnt_width(DRAIN_CYCLES);

    logic [CW-1:0] r_cnt;

    // Saturates at DRAIN_CYCLES so it can never wrap back to a low count.
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != CW'(DRAIN_CYCLES))) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_last_c = (r_cnt == CW'(DRAIN_CYCLES - 1));

endmodule

// File: rtl/isr_seq_ctrl.sv
// Interrupt entry/exit sequencer for the 5-stage pipeline.
// Latches a request, waits for a drained pipeline, redirects fetch to the ISR
// vector while saving the return PC, and redirects back to it on RETI.
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   i_int_req        - interrupt request level
//   i_ie             - global interrupt enable
//   i_ctrl_xfer      - jump/branch taking effect in EX/MEM
//   i_stall          - hazard-unit stall
//   i_reti           - RETI in EX/MEM
//   i_resume_pc      - PC of first unexecuted instruction (IF/ID)
//   o_pc_src         - fetch PC select (SEQ/VEC/EPC)
//   o_vector         - ISR entry address
//   o_epc            - saved return PC
//   o_flush_ifid/idex- pipeline register flushes
//   o_int_ack        - one-cycle acknowledge
//   o_in_isr         - servicing an interrupt
module isr_seq_ctrl
    import isr_seq_ctrl_pkg::*;
#(
    parameter int unsigned    AW           = 32,
    parameter logic [AW-1:0]  VECTOR       = AW'(32'h0000_0100),
    parameter int unsigned    DRAIN_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_int_req,
    input  logic          i_ie,
    input  logic          i_ctrl_xfer,
    input  logic          i_stall,
    input  logic          i_reti,
    input  logic [AW-1:0] i_resume_pc,
    output logic [1:0]    o_pc_src,
    output logic [AW-1:0] o_vector,
    output logic [AW-1:0] o_epc,
    output logic          o_flush_ifid,
    output logic          o_flush_idex,
    output logic          o_int_ack,
    output logic          o_in_isr
);

    isr_state_e    r_state;
    logic          r_pending;
    logic [AW-1:0] r_epc;
    logic [1:0]    r_pc_src;
    logic          r_flush_ifid;
    logic          r_flush_idex;
    logic          r_int_ack;
    logic          r_in_isr;

    logic w_in_drain;
    logic w_cnt_clr;
    logic w_cnt_inc;
    logic w_cnt_last;

    // A redirect restarts the drain because its target is not yet in IF/ID.
    assign w_in_drain = (r_state == ST_DRAIN);
    assign w_cnt_clr  = (r_state == ST_IDLE) || (w_in_drain && (!i_ie || i_ctrl_xfer));
    assign w_cnt_inc  = w_in_drain && i_ie && !i_ctrl_xfer && !i_stall;

    isr_drain_cnt #(
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) u_drain_cnt (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (w_cnt_clr),
        .i_inc    (w_cnt_inc),
        .o_last_c (w_cnt_last)
    );

    // Sequencer; outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_pending    <= 1'b0;
            r_epc        <= '0;
            r_pc_src     <= PC_SRC_SEQ;
            r_flush_ifid <= 1'b0;
            r_flush_idex <= 1'b0;
            r_int_ack    <= 1'b0;
            r_in_isr     <= 1'b0;
        end else begin
            r_pc_src     <= PC_SRC_SEQ;
            r_flush_ifid <= 1'b0;
            r_flush_idex <= 1'b0;
            r_int_ack    <= 1'b0;

            // Requests while servicing are dropped, not queued.
            if (i_int_req && (r_state != ST_SERVICE) && (r_state != ST_RETURN)) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_pending && i_ie) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!i_ie) begin
                        r_state <= ST_IDLE;
                    end else if (!i_ctrl_xfer && !i_stall && w_cnt_last) begin
                        r_state      <= ST_ENTER;
                        r_pc_src     <= PC_SRC_VEC;
                        r_flush_ifid <= 1'b1;
                        r_flush_idex <= 1'b1;
                        r_int_ack    <= 1'b1;
                    end
                end
                ST_ENTER: begin
                    // The acknowledged request is consumed here, even if still held.
                    r_epc     <= i_resume_pc;
                    r_pending <= 1'b0;
                    r_state   <= ST_SERVICE;
                    r_in_isr  <= 1'b1;
                end
                ST_SERVICE: begin
                    if (i_reti) begin
                        r_state      <= ST_RETURN;
                        r_pc_src     <= PC_SRC_EPC;
                        r_flush_ifid <= 1'b1;
                        r_flush_idex <= 1'b1;
                    end
                end
                ST_RETURN: begin
                    r_state  <= ST_IDLE;
                    r_in_isr <= 1'b0;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_in_isr <= 1'b0;
                end
            endcase
        end
    end

    assign o_pc_src     = r_pc_src;
    assign o_vector     = VECTOR;
    assign o_epc        = r_epc;
    assign o_flush_ifid = r_flush_ifid;
    assign o_flush_idex = r_flush_idex;
    assign o_int_ack    = r_int_ack;
    assign o_in_isr     = r_in_isr;

endmodule

// File: tb/tb_isr_seq_ctrl.sv
// Bench for isr_seq_ctrl: expected acknowledges (cycle and saved PC) are queued
// when requests are driven and matched when the DUT acknowledges.
module tb_isr_seq_ctrl;

    localparam int unsigned AW    = 32;
    localparam int unsigned DRAIN = 2;
    localparam logic [31:0] VEC   = 32'h0000_0100;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_int_req;
    logic          i_ie;
    logic          i_ctrl_xfer;
    logic          i_stall;
    logic          i_reti;
    logic [AW-1:0] i_resume_pc;
    logic [1:0]    o_pc_src;
    logic [AW-1:0] o_vector;
    logic [AW-1:0] o_epc;
    logic          o_flush_ifid;
    logic          o_flush_idex;
    logic          o_int_ack;
    logic          o_in_isr;

    isr_seq_ctrl #(
        .AW           (AW),
        .VECTOR       (VEC),
        .DRAIN_CYCLES (DRAIN)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .i_int_req    (i_int_req),
        .i_ie         (i_ie),
        .i_ctrl_xfer  (i_ctrl_xfer),
        .i_stall      (i_stall),
        .i_reti       (i_reti),
        .i_resume_pc  (i_resume_pc),
        .o_pc_src     (o_pc_src),
        .o_vector     (o_vector),
        .o_epc        (o_epc),
        .o_flush_ifid (o_flush_ifid),
        .o_flush_idex (o_flush_idex),
        .o_int_ack    (o_int_ack),
        .o_in_isr     (o_in_isr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] epc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   epc_due = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Acknowledge monitor: each ack must match the oldest queued expectation.
    always @(negedge clk) begin
        if (epc_due) begin
            epc_due = 1'b0;
            chk("svc_epc", o_epc, cur.epc);
            chk("svc_in_isr", 32'(o_in_isr), 32'd1);
            chk("svc_pc_src", 32'(o_pc_src), 32'd0);
        end
        if (o_int_ack) begin
            if (sb.size() == 0) begin
                chk("spurious_ack", 32'(o_int_ack), 32'd0);
            end else begin
                cur = sb.pop_front();
                chk("ack_cycle", cyc, cur.cyc);
                chk("ack_pc_src", 32'(o_pc_src), 32'd1);
                chk("ack_flush_ifid", 32'(o_flush_ifid), 32'd1);
                chk("ack_flush_idex", 32'(o_flush_idex), 32'd1);
                chk("ack_in_isr", 32'(o_in_isr), 32'd0);
                epc_due = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_exp(input int delay_cycles, input logic [31:0] epc_exp);
        exp_t e;
        e.cyc = cyc + delay_cycles;
        e.epc = epc_exp;
        sb.push_back(e);
    endtask

    // One-cycle request pulse; optionally queue the acknowledge it should cause.
    task automatic pulse_int(input bit expect_ack, input int extra, input logic [31:0] epc_exp);
        i_int_req = 1'b1;
        if (expect_ack) push_exp(int'(DRAIN) + 2 + extra, epc_exp);
        tick();
        i_int_req = 1'b0;
    endtask

    task automatic do_reti();
        i_reti = 1'b1;
        tick();
        i_reti = 1'b0;
        chk("ret_pc_src", 32'(o_pc_src), 32'd2);
        chk("ret_flush_ifid", 32'(o_flush_ifid), 32'd1);
        chk("ret_flush_idex", 32'(o_flush_idex), 32'd1);
        chk("ret_in_isr", 32'(o_in_isr), 32'd1);
        tick();
        chk("idle_pc_src", 32'(o_pc_src), 32'd0);
        chk("idle_flush", 32'({o_flush_ifid, o_flush_idex}), 32'd0);
        chk("idle_in_isr", 32'(o_in_isr), 32'd0);
    endtask

    task automatic finish_service();
        step(10);
        chk("in_service", 32'(o_in_isr), 32'd1);
        do_reti();
    endtask

    initial begin
        reset       = 1'b1;
        i_int_req   = 1'b1;
        i_ie        = 1'b1;
        i_ctrl_xfer = 1'b0;
        i_stall     = 1'b0;
        i_reti      = 1'b0;
        i_resume_pc = 32'h40;

        // Reset holds everything quiet even with a request present.
        step(2);
        chk("rst_pc_src", 32'(o_pc_src), 32'd0);
        chk("rst_epc", o_epc, 32'd0);
        chk("rst_ack", 32'(o_int_ack), 32'd0);
        chk("rst_in_isr", 32'(o_in_isr), 32'd0);
        chk("vector", o_vector, VEC);

        // First entry right after reset release, then basic exit.
        reset = 1'b0;
        push_exp(int'(DRAIN) + 2, 32'h40);
        tick();
        i_int_req = 1'b0;
        finish_service();

        // Basic entry/exit with a different return PC.
        i_resume_pc = 32'h44;
        pulse_int(1'b1, 0, 32'h44);
        finish_service();

        // Redirect in the second drain cycle restarts the count: +2 cycles.
        i_resume_pc = 32'h60;
        pulse_int(1'b1, 2, 32'h60);
        step(2);
        i_ctrl_xfer = 1'b1;
        tick();
        i_ctrl_xfer = 1'b0;
        finish_service();

        // Three stall cycles hold the count: +3 cycles; epc follows resume_pc.
        i_resume_pc = 32'h70;
        pulse_int(1'b1, 3, 32'h88);
        tick();
        i_stall = 1'b1;
        i_resume_pc = 32'h88;
        step(3);
        i_stall = 1'b0;
        finish_service();

        // Masked request stays pending; entry follows once ie rises.
        i_ie = 1'b0;
        i_resume_pc = 32'h90;
        pulse_int(1'b0, 0, 32'h0);
        step(10);
        i_ie = 1'b1;
        push_exp(int'(DRAIN) + 1, 32'h90);
        finish_service();

        // Dropping ie during drain returns to idle with the request retained.
        i_resume_pc = 32'hA0;
        pulse_int(1'b0, 0, 32'h0);
        tick();
        i_ie = 1'b0;
        step(4);
        i_ie = 1'b1;
        push_exp(int'(DRAIN) + 1, 32'hA0);
        step(10);
        chk("drain_ie_in_isr", 32'(o_in_isr), 32'd1);

        // Request during service is dropped: no second acknowledge.
        pulse_int(1'b0, 0, 32'h0);
        step(2);
        do_reti();
        step(10);
        chk("nest_in_isr", 32'(o_in_isr), 32'd0);

        // RETI while idle does not redirect.
        i_reti = 1'b1;
        tick();
        i_reti = 1'b0;
        chk("spurious_reti_pc_src", 32'(o_pc_src), 32'd0);
        chk("spurious_reti_flush", 32'({o_flush_ifid, o_flush_idex}), 32'd0);

        // Reset in the middle of service aborts it.
        i_resume_pc = 32'h80;
        pulse_int(1'b1, 0, 32'h80);
        step(8);
        chk("mid_epc", o_epc, 32'h80);
        chk("mid_in_isr", 32'(o_in_isr), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_epc", o_epc, 32'd0);
        chk("mid_rst_in_isr", 32'(o_in_isr), 32'd0);
        chk("mid_rst_pc_src", 32'(o_pc_src), 32'd0);
        step(10);
        chk("mid_rst_stays_idle", 32'(o_in_isr), 32'd0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
